// File: rtl/ram_wr_arbiter.sv
// ram_wr_arbiter
//   Round-robin arbiter for the write port (port A) of a 64x8 simple
//   dual-port block RAM, shared by two req/ack write clients. The RAM drive
//   (ena/wea/addra/dina) goes through one register stage.
//
// Optional feature macro: RAM_WR_ARB_STATS_EN
//   defined   -> stat_cnt0/stat_cnt1 count accepted beats (16-bit, saturating)
//   undefined -> stat_cnt0/stat_cnt1 are tied to 0
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN/addrN/dataN/lastN   client N beat request (held until ackN)
//   ackN                     client N beat accepted this cycle (combinational)
//   ram_ena/wea/addr/din     registered RAM port A drive
//   grant_id                 current owner (valid while busy)
//   busy                     a client owns the port
//   stat_cnt0/stat_cnt1      accepted-beat counters
module ram_wr_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              last0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  input  logic              last1,
  output logic              ack1,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              grant_id,
  output logic              busy,
  output logic [15:0]       stat_cnt0,
  output logic [15:0]       stat_cnt1
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic [7:0]        burst_inc;
  logic              grant_id_q, grant_id_d;
  logic              ram_ena_q, ram_ena_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              acc0, acc1;
  logic              release_own;

  // Arbitration FSM: next state, burst counter, rr pointer, acks.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    burst_cnt_d = burst_cnt_q;
    grant_id_d  = grant_id_q;
    acc0        = 1'b0;
    acc1        = 1'b0;
    release_own = 1'b0;
    burst_inc   = burst_cnt_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        // On a tie the client that did not own the port last wins.
        if (req0 && req1) begin
          if (rr_q) begin
            state_d    = OWN0;
            grant_id_d = 1'b0;
          end else begin
            state_d    = OWN1;
            grant_id_d = 1'b1;
          end
        end else if (req0) begin
          state_d    = OWN0;
          grant_id_d = 1'b0;
        end else if (req1) begin
          state_d    = OWN1;
          grant_id_d = 1'b1;
        end
      end

      OWN0: begin
        if (req0) begin
          acc0        = 1'b1;
          burst_cnt_d = burst_inc;
          release_own = last0 || (burst_inc == MAX_BURST_C);
        end else begin
          release_own = 1'b1;
        end
        if (release_own) begin
          rr_d        = 1'b0;
          burst_cnt_d = '0;
          // Hand over directly when the other client is waiting.
          if (req1) begin
            state_d    = OWN1;
            grant_id_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      OWN1: begin
        if (req1) begin
          acc1        = 1'b1;
          burst_cnt_d = burst_inc;
          release_own = last1 || (burst_inc == MAX_BURST_C);
        end else begin
          release_own = 1'b1;
        end
        if (release_own) begin
          rr_d        = 1'b1;
          burst_cnt_d = '0;
          if (req0) begin
            state_d    = OWN0;
            grant_id_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // RAM drive: strobe for one cycle after an accepted beat, address and
  // data hold their last value otherwise.
  always_comb begin
    ram_ena_d  = acc0 || acc1;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (acc0) begin
      ram_addr_d = addr0;
      ram_din_d  = data0;
    end else if (acc1) begin
      ram_addr_d = addr1;
      ram_din_d  = data1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b1;
      burst_cnt_q <= '0;
      grant_id_q  <= 1'b0;
      ram_ena_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      burst_cnt_q <= burst_cnt_d;
      grant_id_q  <= grant_id_d;
      ram_ena_q   <= ram_ena_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
    end
  end

  assign ack0     = acc0;
  assign ack1     = acc1;
  assign ram_ena  = ram_ena_q;
  assign ram_wea  = ram_ena_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

`ifdef RAM_WR_ARB_STATS_EN
  logic [15:0] stat_cnt0_q, stat_cnt0_d;
  logic [15:0] stat_cnt1_q, stat_cnt1_d;

  always_comb begin
    stat_cnt0_d = stat_cnt0_q;
    stat_cnt1_d = stat_cnt1_q;
    if (acc0 && (stat_cnt0_q != '1)) stat_cnt0_d = stat_cnt0_q + 16'd1;
    if (acc1 && (stat_cnt1_q != '1)) stat_cnt1_d = stat_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt0_q <= '0;
      stat_cnt1_q <= '0;
    end else begin
      stat_cnt0_q <= stat_cnt0_d;
      stat_cnt1_q <= stat_cnt1_d;
    end
  end

  assign stat_cnt0 = stat_cnt0_q;
  assign stat_cnt1 = stat_cnt1_q;
`else
  assign stat_cnt0 = '0;
  assign stat_cnt1 = '0;
`endif

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Self-checking bench for ram_wr_arbiter: directed scenarios plus a random
// phase, all checked every cycle against a behavioural model of the arbiter.
module tb_ram_wr_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, last0, req1, last1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          ack0, ack1, ram_ena, ram_wea, grant_id, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [15:0]   stat_cnt0, stat_cnt1;

  ram_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .last1(last1), .ack1(ack1),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din),
    .grant_id(grant_id), .busy(busy), .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: owner -1 = nobody, otherwise client index.
  int          m_owner, m_cnt, m_rr, m_gid;
  bit          m_ena, m_a0, m_a1;
  int          m_addr, m_din, m_st0, m_st1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_rr = 1; m_gid = 0;
    m_ena = 0; m_addr = 0; m_din = 0; m_st0 = 0; m_st1 = 0;
    m_a0 = 0; m_a1 = 0;
  endtask

  task automatic model_step();
    bit xreq, xlast, oreq, rel;
    int nxt;
    m_a0 = (m_owner == 0) && req0;
    m_a1 = (m_owner == 1) && req1;
    m_ena = m_a0 || m_a1;
    if (m_a0) begin m_addr = int'(addr0); m_din = int'(data0); end
    if (m_a1) begin m_addr = int'(addr1); m_din = int'(data1); end
`ifdef RAM_WR_ARB_STATS_EN
    if (m_a0 && m_st0 < 65535) m_st0++;
    if (m_a1 && m_st1 < 65535) m_st1++;
`endif
    if (m_owner < 0) begin
      if (req0 && req1) nxt = 1 - m_rr;
      else if (req0)    nxt = 0;
      else if (req1)    nxt = 1;
      else              nxt = -1;
    end else begin
      xreq  = (m_owner == 0) ? req0 : req1;
      xlast = (m_owner == 0) ? last0 : last1;
      oreq  = (m_owner == 0) ? req1 : req0;
      if (xreq) m_cnt++;
      rel = !xreq || xlast || (m_cnt == MB);
      if (rel) begin
        m_rr  = m_owner;
        m_cnt = 0;
        nxt   = oreq ? 1 - m_owner : -1;
      end else begin
        nxt = m_owner;
      end
    end
    m_owner = nxt;
    if (nxt >= 0) m_gid = nxt;
  endtask

  task automatic compare_all();
    chk("ack0",     32'(ack0),      32'((m_owner == 0) && req0));
    chk("ack1",     32'(ack1),      32'((m_owner == 1) && req1));
    chk("busy",     32'(busy),      32'(m_owner >= 0));
    chk("grant_id", 32'(grant_id),  32'(m_gid));
    chk("ram_ena",  32'(ram_ena),   32'(m_ena));
    chk("ram_wea",  32'(ram_wea),   32'(m_ena));
    chk("ram_addr", 32'(ram_addr),  32'(m_addr));
    chk("ram_din",  32'(ram_din),   32'(m_din));
    chk("stat0",    32'(stat_cnt0), 32'(m_st0));
    chk("stat1",    32'(stat_cnt1), 32'(m_st1));
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic adv();
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0 = 0; last0 = 0; addr0 = '0; data0 = '0;
    req1 = 0; last1 = 0; addr1 = '0; data1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    idle_inputs();
    settle();
    adv();
    rst = 1'b0;
  endtask

  task automatic rnd_client(input bit acked, inout logic r, inout logic [AW-1:0] a,
                            inout logic [DW-1:0] d, inout logic l);
    if (acked) begin
      r = ($urandom_range(0, 9) < 7);
    end else if (r) begin
      if ($urandom_range(0, 19) == 0) r = 0;
    end else begin
      r = ($urandom_range(0, 9) < 4);
    end
    if (acked || !r) begin
      a = AW'($urandom);
      d = DW'($urandom);
      l = ($urandom_range(0, 9) < 3);
    end
  endtask

  initial begin
    int b, c, n0, n1, s0, r0, r1, ph, wr;

    // ---- reset values ----
    rst = 1'b1;
    model_reset();
    idle_inputs();
    @(negedge clk);
    settle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ena",  32'(ram_ena), 32'd0);
    adv();
    rst = 1'b0;

    // ---- 1: single client, 4-beat burst ----
    b = 0;
    for (int k = 0; k < 7; k++) begin
      req0 = (b < 4); addr0 = AW'(b); data0 = DW'(8'hA0 + b); last0 = (b == 3);
      settle();
      chk("s1_ack0", 32'(ack0),    32'((k >= 1 && k <= 4) ? 1 : 0));
      chk("s1_ena",  32'(ram_ena), 32'((k >= 2 && k <= 5) ? 1 : 0));
      chk("s1_busy", 32'(busy),    32'((k >= 1 && k <= 4) ? 1 : 0));
      if (k == 5) begin
        chk("s1_addr", 32'(ram_addr), 32'd3);
        chk("s1_din",  32'(ram_din),  32'hA3);
      end
      adv();
      if (m_a0) b++;
    end

    // ---- 2: simultaneous single-beat requests, 10 rounds ----
    do_reset();
    n0 = 0; n1 = 0; c = 0;
    while ((n0 < 10 || n1 < 10) && c < 60) begin
      req0 = (n0 < 10); addr0 = AW'(n0);      data0 = DW'(8'h10 + n0); last0 = 1;
      req1 = (n1 < 10); addr1 = AW'(32 + n1); data1 = DW'(8'h50 + n1); last1 = 1;
      settle();
      if (c == 1) begin
        chk("s2_first_ack0", 32'(ack0), 32'd1);
        chk("s2_first_ack1", 32'(ack1), 32'd0);
      end
      if (c == 2) begin
        chk("s2_second_ack1", 32'(ack1), 32'd1);
        chk("s2_second_gid",  32'(grant_id), 32'd1);
      end
      if (c == 3) chk("s2_third_ack0", 32'(ack0), 32'd1);
      adv();
      if (m_a0) n0++;
      if (m_a1) n1++;
      c++;
    end
    chk("s2_timeout", 32'(c < 60), 32'd1);
    chk("s2_cycles", 32'(c), 32'd21);
    idle_inputs();
    settle();
`ifdef RAM_WR_ARB_STATS_EN
    chk("s6_stat0", 32'(stat_cnt0), 32'd10);
    chk("s6_stat1", 32'(stat_cnt1), 32'd10);
`else
    chk("s6_stat0", 32'(stat_cnt0), 32'd0);
    chk("s6_stat1", 32'(stat_cnt1), 32'd0);
`endif
    adv();

    // ---- 3: burst cap with competing client ----
    do_reset();
    s0 = 0; r0 = 0; r1 = 0; ph = 0; c = 0;
    while (s0 < 20 && c < 120) begin
      req0 = 1; addr0 = AW'(s0); data0 = DW'(s0); last0 = 0;
      req1 = 1; addr1 = AW'($urandom); data1 = DW'($urandom); last1 = 0;
      settle();
      if (ph == 0) begin
        if (ack1) ph = 1; else if (ack0) r0++;
      end
      if (ph == 1) begin
        if (ack0) ph = 2; else if (ack1) r1++;
      end
      adv();
      if (m_a0) s0++;
      c++;
    end
    chk("s3_timeout", 32'(c < 120), 32'd1);
    chk("s3_run0", 32'(r0), 32'd8);
    chk("s3_run1", 32'(r1), 32'd8);
    chk("s3_regain", 32'(ph), 32'd2);
    idle_inputs();

    // ---- 4: request dropped after 3 of 5 beats ----
    do_reset();
    b = 0; wr = 0;
    for (int k = 0; k < 9; k++) begin
      req0 = (b < 3); addr0 = AW'(10 + b); data0 = DW'(8'hC0 + b); last0 = (b == 4);
      settle();
      if (ram_ena) wr++;
      adv();
      if (m_a0) b++;
    end
    chk("s4_writes", 32'(wr), 32'd3);
    settle();
    chk("s4_busy", 32'(busy), 32'd0);
    adv();

    // ---- 5: reset during OWN1 with a pending write ----
    do_reset();
    b = 0; c = 0;
    while (b < 2 && c < 10) begin
      req1 = 1; addr1 = AW'(20 + b); data1 = DW'(8'hE0 + b); last1 = 0;
      settle();
      adv();
      if (m_a1) b++;
      c++;
    end
    chk("s5_timeout", 32'(c < 10), 32'd1);
    #1;
    chk("s5_pending", 32'(ram_ena), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("s5_rst_ena",  32'(ram_ena), 32'd0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_ack1", 32'(ack1), 32'd0);
    @(negedge clk);
    settle();
    adv();
    rst = 1'b0;
    req0 = 1; last0 = 1; addr0 = AW'(1); data0 = 8'h11;
    req1 = 1; last1 = 1; addr1 = AW'(2); data1 = 8'h22;
    settle();
    adv();
    settle();
    chk("s5_tie_ack0", 32'(ack0), 32'd1);
    chk("s5_tie_ack1", 32'(ack1), 32'd0);
    adv();

    // ---- random phase ----
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      settle();
      adv();
      rnd_client(m_a0, req0, addr0, data0, last0);
      rnd_client(m_a1, req1, addr1, data1, last1);
    end
    idle_inputs();
    settle();
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
